// File: rtl/score_board.sv
// N-player score keeper: counts one point per rising win edge, latches the match
// winner at MAX_SCORE, freezes play and blinks the winner's active-low digit.

module score_board_digit #(
  parameter int SCORE_W = 3
) (
  input  logic [SCORE_W-1:0] value,
  input  logic               blank,
  output logic [6:0]         hex
);
  logic [3:0] v;
  logic [6:0] seg;

  assign v = 4'(value);

  always_comb begin
    seg = 7'b1000000;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end

  assign hex = blank ? 7'b1111111 : seg;
endmodule

module score_board #(
  parameter  int NUM_PLAYERS  = 2,
  parameter  int SCORE_W      = 3,
  parameter  int MAX_SCORE    = 7,
  parameter  int BLINK_CYCLES = 25_000_000,
  localparam int WID          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic [NUM_PLAYERS-1:0]         win,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS*7-1:0]       HEX,
  output logic                           game_over,
  output logic [WID-1:0]                 winner,
  output logic                           point
);
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic {PLAY, OVER} state_t;
  state_t state, state_n;

  logic [NUM_PLAYERS-1:0]              win_q, rise;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] sc;
  logic [WID-1:0]                      pidx;
  logic [3:0]                          nhits;
  logic                                accept, hit_max, phase;
  logic [CW-1:0]                       bcnt;

  assign rise = win & ~win_q;

  // Tie rounds (two or more simultaneous edges) score nobody.
  always_comb begin
    pidx  = '0;
    nhits = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (rise[i]) begin
        pidx  = WID'(i);
        nhits = nhits + 4'd1;
      end
    end
  end

  assign accept  = (state == PLAY) && (nhits == 4'd1) && !new_game;
  assign hit_max = (sc[pidx] + SCORE_W'(1)) == SCORE_W'(MAX_SCORE);

  always_ff @(posedge clk) begin
    if (reset) state <= PLAY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      PLAY:    if (accept && hit_max) state_n = OVER;
      OVER:    state_n = OVER;
      default: state_n = PLAY;
    endcase
    if (new_game) state_n = PLAY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '1;
      sc     <= '0;
      point  <= 1'b0;
      winner <= '0;
      bcnt   <= '0;
      phase  <= 1'b0;
    end else begin
      win_q <= win;
      point <= accept;
      if (new_game) begin
        sc     <= '0;
        winner <= '0;
        bcnt   <= '0;
        phase  <= 1'b0;
      end else if (accept) begin
        sc[pidx] <= sc[pidx] + SCORE_W'(1);
        if (hit_max) begin
          winner <= pidx;
          bcnt   <= '0;
          phase  <= 1'b0;
        end
      end else if (state == OVER) begin
        if (bcnt == CW'(BLINK_CYCLES - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + CW'(1);
        end
      end
    end
  end

  assign score     = sc;
  assign game_over = (state == OVER);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_dig
    score_board_digit #(.SCORE_W(SCORE_W)) u_dig (
      .value (sc[g]),
      .blank (game_over && phase && (winner == WID'(g))),
      .hex   (HEX[g*7 +: 7])
    );
  end
endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: hand-derived vector table for the game scenarios, then
// random play checked against an elapsed-time behavioural model.

module tb_score_board;
  localparam int NP = 2, SW = 3, MX = 3, BC = 4;
  localparam bit [6:0] H0 = 7'b1000000, H1 = 7'b1111001, H2 = 7'b0100100,
                       H3 = 7'b0110000, BL = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset, new_game;
  logic [1:0]    win;
  logic [NP*SW-1:0] score;
  logic [NP*7-1:0]  HEX;
  logic          game_over, point;
  logic [0:0]    winner;

  score_board #(.NUM_PLAYERS(NP), .SCORE_W(SW), .MAX_SCORE(MX), .BLINK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .win(win), .score(score),
    .HEX(HEX), .game_over(game_over), .winner(winner), .point(point)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit ng; bit [1:0] w;
    int s0; int s1; bit pt; bit go; int wn; bit [6:0] h0; bit [6:0] h1;
  } vec_t;
  vec_t tbl[$];

  int checks = 0, errors = 0;

  bit [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                         7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                         7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: scores as ints, blink derived from cycles spent in OVER.
  bit [1:0] mprev;
  int ms[2];
  bit mover, mpt;
  int mwin, mt;

  task automatic mstep(input bit rst, input bit ng, input bit [1:0] w);
    bit [1:0] e;
    e = w & ~mprev;
    mpt = 1'b0;
    if (rst) begin
      mprev = 2'b11; ms[0] = 0; ms[1] = 0; mover = 0; mwin = 0; mt = 0;
    end else begin
      mprev = w;
      if (ng) begin
        ms[0] = 0; ms[1] = 0; mover = 0; mwin = 0; mt = 0;
      end else if (!mover) begin
        if ($countones(e) == 1) begin
          int p;
          p = e[1] ? 1 : 0;
          ms[p]++;
          mpt = 1'b1;
          if (ms[p] == MX) begin mover = 1; mwin = p; mt = 0; end
        end
      end else begin
        mt++;
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit ng, input bit [1:0] w);
    @(negedge clk);
    reset = rst; new_game = ng; win = w;
    @(posedge clk);
    mstep(rst, ng, w);
    #1;
  endtask

  task automatic add(input int n, input bit rst, input bit ng, input bit [1:0] w,
                     input int s0, input int s1, input bit pt, input bit go, input int wn,
                     input bit [6:0] h0, input bit [6:0] h1);
    vec_t v;
    v = '{rst, ng, w, s0, s1, pt, go, wn, h0, h1};
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check_model(input int c);
    bit [6:0] eh;
    check($sformatf("rnd%0d s0", c), int'(score[2:0]), ms[0]);
    check($sformatf("rnd%0d s1", c), int'(score[5:3]), ms[1]);
    check($sformatf("rnd%0d point", c), int'(point), int'(mpt));
    check($sformatf("rnd%0d over", c), int'(game_over), int'(mover));
    check($sformatf("rnd%0d winner", c), int'(winner), mwin);
    for (int i = 0; i < 2; i++) begin
      eh = (mover && ((mt / BC) % 2 == 1) && mwin == i) ? BL : seg[ms[i]];
      check($sformatf("rnd%0d hex%0d", c, i), int'(HEX[i*7 +: 7]), int'(eh));
    end
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0; win = 2'b00;

    //  n  rst ng win   s0 s1 pt go wn h0  h1
    add(2, 1, 0, 2'b11, 0, 0, 0, 0, 0, H0, H0);   // reset with win held
    add(5, 0, 0, 2'b11, 0, 0, 0, 0, 0, H0, H0);   // held line never counts
    add(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, H0, H0);
    add(1, 0, 0, 2'b01, 1, 0, 1, 0, 0, H1, H0);
    add(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, H1, H0);
    add(1, 0, 0, 2'b01, 2, 0, 1, 0, 0, H2, H0);
    add(1, 0, 0, 2'b00, 2, 0, 0, 0, 0, H2, H0);
    add(1, 0, 0, 2'b01, 3, 0, 1, 1, 0, H3, H0);   // match point
    add(3, 0, 0, 2'b00, 3, 0, 0, 1, 0, H3, H0);
    add(4, 0, 0, 2'b00, 3, 0, 0, 1, 0, BL, H0);
    add(1, 0, 0, 2'b00, 3, 0, 0, 1, 0, H3, H0);
    add(1, 0, 1, 2'b00, 0, 0, 0, 0, 0, H0, H0);   // new game
    add(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, H0, H0);   // tie round
    add(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, H0, H0);
    add(1, 0, 0, 2'b10, 0, 1, 1, 0, 0, H0, H1);
    add(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, H0, H1);
    add(1, 0, 0, 2'b01, 1, 1, 1, 0, 0, H1, H1);
    add(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, H1, H1);
    add(1, 0, 0, 2'b01, 2, 1, 1, 0, 0, H2, H1);
    add(1, 0, 0, 2'b00, 2, 1, 0, 0, 0, H2, H1);
    add(1, 0, 0, 2'b01, 3, 1, 1, 1, 0, H3, H1);
    add(1, 0, 0, 2'b00, 3, 1, 0, 1, 0, H3, H1);
    add(1, 0, 0, 2'b10, 3, 1, 0, 1, 0, H3, H1);   // edge ignored in OVER
    add(1, 0, 0, 2'b00, 3, 1, 0, 1, 0, H3, H1);
    add(1, 0, 1, 2'b01, 0, 0, 0, 0, 0, H0, H0);   // new game beats edge
    add(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, H0, H0);   // discarded edge not replayed
    add(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, H0, H0);
    add(1, 0, 0, 2'b10, 0, 1, 1, 0, 0, H0, H1);   // long hold: one point
    add(9, 0, 0, 2'b10, 0, 1, 0, 0, 0, H0, H1);
    add(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, H0, H1);
    add(1, 0, 0, 2'b10, 0, 2, 1, 0, 0, H0, H2);
    add(1, 0, 0, 2'b00, 0, 2, 0, 0, 0, H0, H2);
    add(1, 0, 0, 2'b01, 1, 2, 1, 0, 0, H1, H2);
    add(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, H1, H2);
    add(1, 0, 0, 2'b01, 2, 2, 1, 0, 0, H2, H2);
    add(1, 0, 0, 2'b00, 2, 2, 0, 0, 0, H2, H2);
    add(1, 0, 0, 2'b01, 3, 2, 1, 1, 0, H3, H2);
    add(3, 0, 0, 2'b00, 3, 2, 0, 1, 0, H3, H2);
    add(1, 0, 0, 2'b00, 3, 2, 0, 1, 0, BL, H2);
    add(1, 1, 0, 2'b00, 0, 0, 0, 0, 0, H0, H0);   // reset mid-blink
    add(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, H0, H0);
    add(1, 0, 0, 2'b10, 0, 1, 1, 0, 0, H0, H1);
    add(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, H0, H1);
    add(1, 0, 0, 2'b10, 0, 2, 1, 0, 0, H0, H2);
    add(1, 0, 0, 2'b00, 0, 2, 0, 0, 0, H0, H2);
    add(1, 0, 0, 2'b10, 0, 3, 1, 1, 1, H0, H3);   // player 1 wins
    add(3, 0, 0, 2'b00, 0, 3, 0, 1, 1, H0, H3);
    add(2, 0, 0, 2'b00, 0, 3, 0, 1, 1, H0, BL);

    foreach (tbl[r]) begin
      cyc(tbl[r].rst, tbl[r].ng, tbl[r].w);
      check($sformatf("row%0d s0", r), int'(score[2:0]), tbl[r].s0);
      check($sformatf("row%0d s1", r), int'(score[5:3]), tbl[r].s1);
      check($sformatf("row%0d point", r), int'(point), int'(tbl[r].pt));
      check($sformatf("row%0d over", r), int'(game_over), int'(tbl[r].go));
      check($sformatf("row%0d winner", r), int'(winner), tbl[r].wn);
      check($sformatf("row%0d hex0", r), int'(HEX[6:0]), int'(tbl[r].h0));
      check($sformatf("row%0d hex1", r), int'(HEX[13:7]), int'(tbl[r].h1));
    end

    // Walk the blink pattern of player 1's win for several half-periods.
    for (int c = 0; c < 12; c++) begin
      cyc(1'b0, 1'b0, 2'b00);
      check($sformatf("blink%0d hex1", c), int'(HEX[13:7]),
            int'((((c + 6) / BC) % 2 == 1) ? BL : H3));
      check($sformatf("blink%0d hex0", c), int'(HEX[6:0]), int'(H0));
    end

    cyc(1'b1, 1'b0, 2'b00);
    for (int c = 0; c < 2000; c++) begin
      bit [1:0] w;
      w = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, w);
      check_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
